// File: rtl/sdio_clk_pkg.sv
// Shared types and constants for the SDIO clock-switch sequencer.
// Select encoding: clk_sel_o=1 picks clk0, 0 picks clk1.
package sdio_clk_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_IDLE,
      ST_GATE_OFF,
      ST_SWITCH,
      ST_SETTLE,
      ST_DONE
   } sw_state_t;

   localparam int DEF_GATE_CYCLES    = 4;
   localparam int DEF_SETTLE_CYCLES  = 8;
   localparam int DEF_TIMEOUT_CYCLES = 1024;

   localparam logic SEL_CLK0 = 1'b1;
   localparam logic SEL_CLK1 = 1'b0;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/sdio_cycle_cnt.sv
// Loadable down-counter; tc_o flags the last cycle of a loaded interval.
// Saturates at zero so an unused load never wraps.
module sdio_cycle_cnt #(
   parameter int W = 4
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   output logic         tc_o
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_cnt <= '0;
      end else if (load_i) begin
         r_cnt <= load_val_i;
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign tc_o = (r_cnt == W'(1));

endmodule

// File: rtl/sdio_clk_switch_ctrl.sv
// Clock-mux switch sequencer: wait bus idle, gate, switch select, settle, ungate, ack.
// Optional bus-idle timeout enabled by SDIO_CLK_SWITCH_TIMEOUT_EN.
module sdio_clk_switch_ctrl
   import sdio_clk_pkg::*;
#(
   parameter int GATE_CYCLES    = DEF_GATE_CYCLES,
   parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic sw_req_i,
   input  logic sw_sel_i,
   input  logic bus_busy_i,
   output logic clk_sel_o,
   output logic clk_en_o,
   output logic sw_ack_o,
   output logic sw_busy_o,
   output logic sw_err_o
);

   localparam int CNT_W = $clog2(max3(GATE_CYCLES, SETTLE_CYCLES, TIMEOUT_CYCLES) + 1);

   sw_state_t        r_state, w_state_next;
   logic             r_target, w_target_next;
   logic             r_idle_seen, w_idle_seen_next;
   logic             r_clk_sel, w_clk_sel_next;
   logic             r_clk_en, r_ack, r_busy, r_err;
   logic             w_err_next;
   logic             w_gated_next;
   logic             w_cnt_load;
   logic [CNT_W-1:0] w_cnt_val;
   logic             w_cnt_tc;
   logic             w_timeout;

   sdio_cycle_cnt #(.W(CNT_W)) u_cnt (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .load_i     (w_cnt_load),
      .load_val_i (w_cnt_val),
      .tc_o       (w_cnt_tc)
   );

`ifdef SDIO_CLK_SWITCH_TIMEOUT_EN
   // Counter was loaded on WAIT_IDLE entry, so tc here means the wait budget is spent.
   assign w_timeout = (r_state == ST_WAIT_IDLE) && w_cnt_tc;
`else
   assign w_timeout = 1'b0;
`endif

   always_comb begin
      w_state_next     = r_state;
      w_target_next    = r_target;
      w_idle_seen_next = r_idle_seen;
      w_clk_sel_next   = r_clk_sel;
      w_err_next       = 1'b0;
      w_cnt_load       = 1'b0;
      w_cnt_val        = '0;
      case (r_state)
         ST_IDLE: begin
            if (sw_req_i) begin
               if (sw_sel_i != r_clk_sel) begin
                  w_target_next    = sw_sel_i;
                  w_idle_seen_next = 1'b0;
                  w_cnt_load       = 1'b1;
                  w_cnt_val        = CNT_W'(TIMEOUT_CYCLES);
                  w_state_next     = ST_WAIT_IDLE;
               end else begin
                  w_state_next = ST_DONE;
               end
            end
         end
         ST_WAIT_IDLE: begin
            // An idle window completing on the last budget cycle still wins.
            if (!bus_busy_i && r_idle_seen) begin
               w_cnt_load   = 1'b1;
               w_cnt_val    = CNT_W'(GATE_CYCLES);
               w_state_next = ST_GATE_OFF;
            end else if (w_timeout) begin
               w_err_next   = 1'b1;
               w_state_next = ST_DONE;
            end else begin
               w_idle_seen_next = !bus_busy_i;
            end
         end
         ST_GATE_OFF: begin
            if (w_cnt_tc) begin
               w_state_next = ST_SWITCH;
            end
         end
         ST_SWITCH: begin
            w_clk_sel_next = r_target;
            w_cnt_load     = 1'b1;
            w_cnt_val      = CNT_W'(SETTLE_CYCLES);
            w_state_next   = ST_SETTLE;
         end
         ST_SETTLE: begin
            if (w_cnt_tc) begin
               w_state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            w_state_next = ST_IDLE;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   assign w_gated_next = (w_state_next == ST_GATE_OFF) ||
                         (w_state_next == ST_SWITCH)   ||
                         (w_state_next == ST_SETTLE);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state     <= ST_IDLE;
         r_target    <= SEL_CLK1;
         r_idle_seen <= 1'b0;
         r_clk_sel   <= SEL_CLK1;
         r_clk_en    <= 1'b1;
         r_ack       <= 1'b0;
         r_busy      <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_target    <= w_target_next;
         r_idle_seen <= w_idle_seen_next;
         r_clk_sel   <= w_clk_sel_next;
         r_clk_en    <= !w_gated_next;
         r_ack       <= (w_state_next == ST_DONE);
         r_busy      <= (w_state_next != ST_IDLE);
         r_err       <= w_err_next;
      end
   end

   assign clk_sel_o = r_clk_sel;
   assign clk_en_o  = r_clk_en;
   assign sw_ack_o  = r_ack;
   assign sw_busy_o = r_busy;
   assign sw_err_o  = r_err;

endmodule

// File: tb/tb_sdio_clk_switch_ctrl.sv
// Randomized bench for sdio_clk_switch_ctrl against a cycle-timeline reference model.
// Define SDIO_CLK_SWITCH_TIMEOUT_EN to exercise the timeout build.
module tb_sdio_clk_switch_ctrl;

   localparam int G = 4;
   localparam int S = 8;
   localparam int T = 16;
`ifdef SDIO_CLK_SWITCH_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   logic clk_i      = 1'b0;
   logic rst_i      = 1'b1;
   logic sw_req_i   = 1'b0;
   logic sw_sel_i   = 1'b0;
   logic bus_busy_i = 1'b0;
   logic clk_sel_o, clk_en_o, sw_ack_o, sw_busy_o, sw_err_o;

   int   n_checks = 0;
   int   n_errors = 0;
   logic model_sel = 1'b0;
   logic pat [0:63];

   always #5 clk_i = ~clk_i;

   sdio_clk_switch_ctrl #(
      .GATE_CYCLES    (G),
      .SETTLE_CYCLES  (S),
      .TIMEOUT_CYCLES (T)
   ) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .sw_req_i   (sw_req_i),
      .sw_sel_i   (sw_sel_i),
      .bus_busy_i (bus_busy_i),
      .clk_sel_o  (clk_sel_o),
      .clk_en_o   (clk_en_o),
      .sw_ack_o   (sw_ack_o),
      .sw_busy_o  (sw_busy_o),
      .sw_err_o   (sw_err_o)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic clear_pat();
      for (int i = 0; i < 64; i++) pat[i] = 1'b0;
   endtask

   // First edge at which two consecutive idle samples have been seen in WAIT_IDLE.
   function automatic int find_k();
      for (int e = 2; e < 64; e++)
         if (!pat[e-1] && !pat[e]) return e;
      return 1000;
   endfunction

   // Edge 0 samples the request; outputs seen after edge e belong to cycle e+1.
   task automatic run_xact(input string name, input logic sel, input bit keep);
      int   k, g0, ack_c, n;
      bit   fast, tmo;
      logic old_sel, new_sel;
      fast    = (sel == model_sel);
      k       = find_k();
      tmo     = !fast && TMO_EN && (k > T);
      g0      = k + 1;
      ack_c   = fast ? 1 : (tmo ? T + 1 : g0 + G + S + 1);
      old_sel = model_sel;
      new_sel = (fast || tmo) ? model_sel : sel;
      for (int e = 0; e < ack_c; e++) begin
         @(negedge clk_i);
         sw_req_i   = 1'b1;
         sw_sel_i   = (e == 0) ? sel : 1'($urandom);
         bus_busy_i = (e < 64) ? pat[e] : 1'b0;
         @(posedge clk_i);
         #1;
         n = e + 1;
         check_val({name, " sel"}, clk_sel_o,
                   (!fast && !tmo && n >= g0 + G + 1) ? new_sel : old_sel);
         check_val({name, " en"}, clk_en_o,
                   (fast || tmo) ? 1'b1 : !(n >= g0 && n <= g0 + G + S));
         check_val({name, " ack"}, sw_ack_o, n == ack_c);
         check_val({name, " err"}, sw_err_o, tmo && n == ack_c);
         check_val({name, " busy"}, sw_busy_o, 1'b1);
      end
      @(negedge clk_i);
      sw_req_i   = keep;
      bus_busy_i = 1'($urandom);
      @(posedge clk_i);
      #1;
      check_val({name, " post busy"}, sw_busy_o, 1'b0);
      check_val({name, " post ack"}, sw_ack_o, 1'b0);
      check_val({name, " post en"}, clk_en_o, 1'b1);
      check_val({name, " post sel"}, clk_sel_o, new_sel);
      model_sel = new_sel;
      $display("xact %s sel=%0d fast=%0d timeout=%0d idle_edge=%0d ack_cycle=%0d",
               name, sel, fast, tmo, k, ack_c);
   endtask

   initial begin
      repeat (3) @(posedge clk_i);
      #1;
      check_val("reset sel", clk_sel_o, 1'b0);
      check_val("reset en", clk_en_o, 1'b1);
      check_val("reset ack", sw_ack_o, 1'b0);
      check_val("reset busy", sw_busy_o, 1'b0);
      check_val("reset err", sw_err_o, 1'b0);
      @(negedge clk_i);
      rst_i = 1'b0;
      @(negedge clk_i);

      clear_pat();
      run_xact("idle_to_clk0", 1'b1, 1'b0);
      run_xact("fast_same", 1'b1, 1'b0);

      clear_pat();
      for (int i = 1; i <= 10; i++) pat[i] = 1'b1;
      run_xact("busy10", 1'b0, 1'b0);

      clear_pat();
      pat[2] = 1'b1;
      run_xact("glitch", 1'b1, 1'b0);

      clear_pat();
      for (int i = 1; i <= 40; i++) pat[i] = 1'b1;
      run_xact("held_busy", !model_sel, 1'b0);

      clear_pat();
      run_xact("keep_req", !model_sel, 1'b1);
      run_xact("keep_fast", model_sel, 1'b0);

      // Reset while in SETTLE: pending request dropped, gate reopens, select back to 0.
      begin
         logic tgt;
         tgt = !model_sel;
         for (int e = 0; e < 10; e++) begin
            @(negedge clk_i);
            sw_req_i   = 1'b1;
            sw_sel_i   = tgt;
            bus_busy_i = 1'b0;
            @(posedge clk_i);
         end
         #1;
         check_val("pre_rst en", clk_en_o, 1'b0);
         check_val("pre_rst sel", clk_sel_o, tgt);
         @(negedge clk_i);
         rst_i = 1'b1;
         @(posedge clk_i);
         #1;
         check_val("rst_settle sel", clk_sel_o, 1'b0);
         check_val("rst_settle en", clk_en_o, 1'b1);
         check_val("rst_settle busy", sw_busy_o, 1'b0);
         check_val("rst_settle ack", sw_ack_o, 1'b0);
         @(negedge clk_i);
         rst_i    = 1'b0;
         sw_req_i = 1'b0;
         @(posedge clk_i);
         #1;
         check_val("after_rst ack", sw_ack_o, 1'b0);
         check_val("after_rst busy", sw_busy_o, 1'b0);
         model_sel = 1'b0;
         $display("xact reset_in_settle target=%0d", tgt);
      end

      for (int r = 0; r < 24; r++) begin
         int lvl;
         lvl = $urandom_range(0, 3);
         for (int i = 0; i < 64; i++)
            pat[i] = (i < 50) && ($urandom_range(0, 3) < lvl);
         run_xact($sformatf("rand%0d", r), 1'($urandom), 1'($urandom_range(0, 3) == 0));
      end

      @(negedge clk_i);
      sw_req_i = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
